// File: rtl/slv_guard_isolator.sv
// Isolation and recovery sequencer for a guarded AXI subordinate.
// PASS wires the manager to the subordinate and records outstanding transactions.
// After a trigger it cuts the subordinate off and answers every tracked transaction with SLVERR.
// It then runs a reset request/acknowledge handshake with the subordinate's reset controller and reconnects.
module slv_guard_isolator #(
    parameter int unsigned AxiIdWidth   = 4,
    parameter int unsigned AxiAddrWidth = 32,
    parameter int unsigned AxiDataWidth = 32,
    parameter int unsigned MaxWrTxns    = 16,
    parameter int unsigned MaxRdTxns    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    guard_ena_i,
    input  logic                    trigger_i,
    // manager side
    input  logic                    mst_aw_valid_i,
    output logic                    mst_aw_ready_o,
    input  logic [AxiIdWidth-1:0]   mst_aw_id_i,
    input  logic [AxiAddrWidth-1:0] mst_aw_addr_i,
    input  logic [7:0]              mst_aw_len_i,
    input  logic                    mst_w_valid_i,
    output logic                    mst_w_ready_o,
    input  logic [AxiDataWidth-1:0] mst_w_data_i,
    input  logic                    mst_w_last_i,
    output logic                    mst_b_valid_o,
    input  logic                    mst_b_ready_i,
    output logic [AxiIdWidth-1:0]   mst_b_id_o,
    output logic [1:0]              mst_b_resp_o,
    input  logic                    mst_ar_valid_i,
    output logic                    mst_ar_ready_o,
    input  logic [AxiIdWidth-1:0]   mst_ar_id_i,
    input  logic [AxiAddrWidth-1:0] mst_ar_addr_i,
    input  logic [7:0]              mst_ar_len_i,
    output logic                    mst_r_valid_o,
    input  logic                    mst_r_ready_i,
    output logic [AxiIdWidth-1:0]   mst_r_id_o,
    output logic [AxiDataWidth-1:0] mst_r_data_o,
    output logic [1:0]              mst_r_resp_o,
    output logic                    mst_r_last_o,
    // subordinate side
    output logic                    slv_aw_valid_o,
    input  logic                    slv_aw_ready_i,
    output logic [AxiIdWidth-1:0]   slv_aw_id_o,
    output logic [AxiAddrWidth-1:0] slv_aw_addr_o,
    output logic [7:0]              slv_aw_len_o,
    output logic                    slv_w_valid_o,
    input  logic                    slv_w_ready_i,
    output logic [AxiDataWidth-1:0] slv_w_data_o,
    output logic                    slv_w_last_o,
    input  logic                    slv_b_valid_i,
    output logic                    slv_b_ready_o,
    input  logic [AxiIdWidth-1:0]   slv_b_id_i,
    input  logic [1:0]              slv_b_resp_i,
    output logic                    slv_ar_valid_o,
    input  logic                    slv_ar_ready_i,
    output logic [AxiIdWidth-1:0]   slv_ar_id_o,
    output logic [AxiAddrWidth-1:0] slv_ar_addr_o,
    output logic [7:0]              slv_ar_len_o,
    input  logic                    slv_r_valid_i,
    output logic                    slv_r_ready_o,
    input  logic [AxiIdWidth-1:0]   slv_r_id_i,
    input  logic [AxiDataWidth-1:0] slv_r_data_i,
    input  logic [1:0]              slv_r_resp_i,
    input  logic                    slv_r_last_i,
    // reset handshake and status
    output logic                    rst_req_o,
    input  logic                    rst_stat_i,
    output logic                    irq_o,
    output logic                    busy_o,
    output logic [15:0]             err_cnt_o
);

    localparam int unsigned WCntW = $clog2(MaxWrTxns + 1);
    localparam int unsigned RCntW = $clog2(MaxRdTxns + 1);
    localparam int unsigned WPtrW = (MaxWrTxns > 1) ? $clog2(MaxWrTxns) : 1;
    localparam int unsigned RPtrW = (MaxRdTxns > 1) ? $clog2(MaxRdTxns) : 1;
    localparam logic [1:0]  RespSlvErr = 2'b10;

    typedef enum logic [1:0] {ST_PASS, ST_DRAIN, ST_RESET, ST_RECOVER} state_e;

    state_e                  state_q;
    logic                    rst_req_q, irq_q, busy_q;
    logic [15:0]             err_cnt_q;

    logic [AxiIdWidth-1:0]   wfifo_q [MaxWrTxns];
    logic [WPtrW-1:0]        wwr_ptr_q, wrd_ptr_q;
    logic [WCntW-1:0]        wcnt_q, wpend_q;
    logic [AxiIdWidth-1:0]   rfifo_id_q  [MaxRdTxns];
    logic [7:0]              rfifo_len_q [MaxRdTxns];
    logic [RPtrW-1:0]        rwr_ptr_q, rrd_ptr_q;
    logic [RCntW-1:0]        rcnt_q;
    logic [7:0]              beat_q;

    logic is_pass, is_drain, wfull, rfull;
    logic gen_b_valid, gen_r_valid, gen_r_last;
    logic aw_push, ar_push, b_pop, r_pop, w_last_dec, gen_b_hs, gen_r_last_hs;
    logic [16:0] err_sum;
    logic [15:0] err_cnt_d;

    assign is_pass  = (state_q == ST_PASS);
    assign is_drain = (state_q == ST_DRAIN);
    assign wfull    = (wcnt_q == WCntW'(MaxWrTxns));
    assign rfull    = (rcnt_q == RCntW'(MaxRdTxns));

    // A B is generated only once the W burst of the head write is complete.
    assign gen_b_valid = is_drain && (wcnt_q != '0) && (wpend_q < wcnt_q);
    assign gen_r_valid = is_drain && (rcnt_q != '0);
    assign gen_r_last  = (beat_q == rfifo_len_q[rrd_ptr_q]);

    // Payload fields are wired straight through; only valid/ready are gated.
    assign slv_aw_id_o   = mst_aw_id_i;
    assign slv_aw_addr_o = mst_aw_addr_i;
    assign slv_aw_len_o  = mst_aw_len_i;
    assign slv_w_data_o  = mst_w_data_i;
    assign slv_w_last_o  = mst_w_last_i;
    assign slv_ar_id_o   = mst_ar_id_i;
    assign slv_ar_addr_o = mst_ar_addr_i;
    assign slv_ar_len_o  = mst_ar_len_i;

    // Channel steering: pass-through in PASS, generated error responses in DRAIN, stalled otherwise.
    always_comb begin
        slv_aw_valid_o = 1'b0;
        mst_aw_ready_o = 1'b0;
        slv_w_valid_o  = 1'b0;
        mst_w_ready_o  = 1'b0;
        slv_b_ready_o  = 1'b0;
        mst_b_valid_o  = 1'b0;
        mst_b_id_o     = slv_b_id_i;
        mst_b_resp_o   = slv_b_resp_i;
        slv_ar_valid_o = 1'b0;
        mst_ar_ready_o = 1'b0;
        slv_r_ready_o  = 1'b0;
        mst_r_valid_o  = 1'b0;
        mst_r_id_o     = slv_r_id_i;
        mst_r_data_o   = slv_r_data_i;
        mst_r_resp_o   = slv_r_resp_i;
        mst_r_last_o   = slv_r_last_i;
        case (state_q)
            ST_PASS: begin
                slv_aw_valid_o = mst_aw_valid_i && !wfull;
                mst_aw_ready_o = slv_aw_ready_i && !wfull;
                slv_w_valid_o  = mst_w_valid_i;
                mst_w_ready_o  = slv_w_ready_i;
                slv_b_ready_o  = mst_b_ready_i;
                mst_b_valid_o  = slv_b_valid_i;
                slv_ar_valid_o = mst_ar_valid_i && !rfull;
                mst_ar_ready_o = slv_ar_ready_i && !rfull;
                slv_r_ready_o  = mst_r_ready_i;
                mst_r_valid_o  = slv_r_valid_i;
            end
            ST_DRAIN: begin
                mst_w_ready_o = (wpend_q != '0);
                mst_b_valid_o = gen_b_valid;
                mst_b_id_o    = wfifo_q[wrd_ptr_q];
                mst_b_resp_o  = RespSlvErr;
                mst_r_valid_o = gen_r_valid;
                mst_r_id_o    = rfifo_id_q[rrd_ptr_q];
                mst_r_data_o  = '0;
                mst_r_resp_o  = RespSlvErr;
                mst_r_last_o  = gen_r_last;
            end
            default: ;
        endcase
    end

    assign aw_push       = mst_aw_valid_i && mst_aw_ready_o;
    assign ar_push       = mst_ar_valid_i && mst_ar_ready_o;
    assign b_pop         = mst_b_valid_o && mst_b_ready_i && (wcnt_q != '0);
    assign r_pop         = mst_r_valid_o && mst_r_ready_i && mst_r_last_o && (rcnt_q != '0);
    assign w_last_dec    = mst_w_valid_i && mst_w_ready_o && mst_w_last_i && (wpend_q != '0);
    assign gen_b_hs      = gen_b_valid && mst_b_ready_i;
    assign gen_r_last_hs = gen_r_valid && gen_r_last && mst_r_ready_i;
    assign err_sum       = {1'b0, err_cnt_q} + 17'(gen_b_hs) + 17'(gen_r_last_hs);
    assign err_cnt_d     = err_sum[16] ? 16'hFFFF : err_sum[15:0];

    // Pending-transaction storage; contents are qualified by the counters so need no reset.
    always_ff @(posedge clk_i) begin
        if (aw_push) begin
            wfifo_q[wwr_ptr_q] <= mst_aw_id_i;
        end
        if (ar_push) begin
            rfifo_id_q[rwr_ptr_q]  <= mst_ar_id_i;
            rfifo_len_q[rwr_ptr_q] <= mst_ar_len_i;
        end
    end

    // Pointers, occupancy, W-burst balance, R beat position and error counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wwr_ptr_q <= '0;
            wrd_ptr_q <= '0;
            wcnt_q    <= '0;
            wpend_q   <= '0;
            rwr_ptr_q <= '0;
            rrd_ptr_q <= '0;
            rcnt_q    <= '0;
            beat_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            if (aw_push) wwr_ptr_q <= (wwr_ptr_q == WPtrW'(MaxWrTxns - 1)) ? '0 : wwr_ptr_q + WPtrW'(1);
            if (b_pop)   wrd_ptr_q <= (wrd_ptr_q == WPtrW'(MaxWrTxns - 1)) ? '0 : wrd_ptr_q + WPtrW'(1);
            if (ar_push) rwr_ptr_q <= (rwr_ptr_q == RPtrW'(MaxRdTxns - 1)) ? '0 : rwr_ptr_q + RPtrW'(1);
            if (r_pop)   rrd_ptr_q <= (rrd_ptr_q == RPtrW'(MaxRdTxns - 1)) ? '0 : rrd_ptr_q + RPtrW'(1);
            wcnt_q  <= wcnt_q + WCntW'(aw_push) - WCntW'(b_pop);
            wpend_q <= wpend_q + WCntW'(aw_push) - WCntW'(w_last_dec);
            rcnt_q  <= rcnt_q + RCntW'(ar_push) - RCntW'(r_pop);
            if (gen_r_valid && mst_r_ready_i) begin
                beat_q <= gen_r_last ? 8'd0 : beat_q + 8'd1;
            end
            err_cnt_q <= err_cnt_d;
        end
    end

    // Isolation sequencer with registered irq, busy and reset request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_PASS;
            rst_req_q <= 1'b0;
            irq_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            case (state_q)
                ST_PASS: begin
                    if (guard_ena_i && trigger_i) begin
                        state_q <= ST_DRAIN;
                        irq_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (wcnt_q == '0 && rcnt_q == '0 && wpend_q == '0) begin
                        state_q   <= ST_RESET;
                        rst_req_q <= 1'b1;
                    end
                end
                ST_RESET: begin
                    if (rst_stat_i) begin
                        state_q   <= ST_RECOVER;
                        rst_req_q <= 1'b0;
                    end
                end
                ST_RECOVER: begin
                    if (!rst_stat_i && !trigger_i) begin
                        state_q <= ST_PASS;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_PASS;
            endcase
        end
    end

    assign rst_req_o = rst_req_q;
    assign irq_o     = irq_q;
    assign busy_o    = busy_q;
    assign err_cnt_o = err_cnt_q;

endmodule
